// File: rtl/isr_pkg.sv
// Shared definitions for the in-service register controller: OCW2 command codes,
// acknowledge FSM encoding and a one-hot to index helper.
package isr_pkg;

    localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
    localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
    localparam logic [2:0] OCW2_NOP          = 3'b010;
    localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
    localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
    localparam logic [2:0] OCW2_ROT_NS       = 3'b101;
    localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
    localparam logic [2:0] OCW2_ROT_SP       = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        ACK1 = 1'b1
    } isr_state_e;

    // Index of the lowest set bit; grant is one-hot so this is its level.
    function automatic logic [4:0] onehot_index(input logic [31:0] vec);
        logic [4:0] idx;
        idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/isr_ctrl_if.sv
// Bus between control logic / priority resolver and the in-service register controller.
interface isr_ctrl_if #(
    parameter int NUM_IRQ = 8,
    parameter int LVL_W   = $clog2(NUM_IRQ)
);
    logic               aeoi_mode;
    logic               special_mask_mode;
    logic [NUM_IRQ-1:0] imr;
    logic [NUM_IRQ-1:0] grant;
    logic               inta_pulse;
    logic               ocw2_valid;
    logic [2:0]         ocw2_cmd;
    logic [LVL_W-1:0]   ocw2_level;
    logic [NUM_IRQ-1:0] in_service;
    logic [NUM_IRQ-1:0] last_serviced;
    logic [LVL_W-1:0]   ack_level;
    logic               ack_busy;
    logic               spurious;
    logic [LVL_W-1:0]   lowest_prio;

    modport master (
        output aeoi_mode, special_mask_mode, imr, grant, inta_pulse,
               ocw2_valid, ocw2_cmd, ocw2_level,
        input  in_service, last_serviced, ack_level, ack_busy, spurious, lowest_prio
    );

    modport slave (
        input  aeoi_mode, special_mask_mode, imr, grant, inta_pulse,
               ocw2_valid, ocw2_cmd, ocw2_level,
        output in_service, last_serviced, ack_level, ack_busy, spurious, lowest_prio
    );
endinterface

// File: rtl/isr_prio_scan.sv
// Rotating find-first: returns the first set bit of req starting at lowest_prio+1
// and wrapping upward, i.e. the highest-priority requesting level.
module isr_prio_scan #(
    parameter int NUM_IRQ = 8,
    parameter int LVL_W   = $clog2(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] req,
    input  logic [LVL_W-1:0]   lowest_prio,
    output logic               found,
    output logic [LVL_W-1:0]   level
);

    int                 start_lvl;
    logic [NUM_IRQ-1:0] rot;

    always_comb begin
        start_lvl = int'(lowest_prio) + 1;
        if (start_lvl >= NUM_IRQ) start_lvl = 0;
    end

    // rot[gi] holds the request gi places below the highest-priority slot.
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_rot
        logic [LVL_W-1:0] src;
        always_comb begin
            int s;
            s = start_lvl + gi;
            if (s >= NUM_IRQ) s = s - NUM_IRQ;
            src = LVL_W'(s);
        end
        assign rot[gi] = req[src];
    end

    always_comb begin
        int offset;
        int lvl;
        found  = 1'b0;
        offset = 0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found  = 1'b1;
                offset = k;
            end
        end
        lvl = start_lvl + offset;
        if (lvl >= NUM_IRQ) lvl = lvl - NUM_IRQ;
        level = LVL_W'(lvl);
    end

endmodule

// File: rtl/isr_ctrl.sv
// In-service register controller: INTA acknowledge FSM, AEOI, OCW2 EOI commands,
// special mask and rotating priority. Define ISR_ROTATION_EN to enable rotation.
module isr_ctrl
    import isr_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int LVL_W   = $clog2(NUM_IRQ)
) (
    input logic       clk,
    input logic       reset,
    isr_ctrl_if.slave bus
);

    localparam logic [LVL_W-1:0] TOP_LVL = LVL_W'(NUM_IRQ - 1);

    isr_state_e         state_reg;
    logic [NUM_IRQ-1:0] in_service_reg, in_service_next;
    logic [NUM_IRQ-1:0] last_serviced_reg, last_serviced_next;
    logic [LVL_W-1:0]   lowest_prio_reg, lowest_prio_next;
    logic [LVL_W-1:0]   ack_level_reg;
    logic               ack_busy_reg;
    logic               spurious_reg;
`ifdef ISR_ROTATION_EN
    logic               auto_rotate_reg, auto_rotate_next;
`endif

    logic [NUM_IRQ-1:0] clr_mask, set_mask, eligible;
    logic [LVL_W-1:0]   scan_level, grant_level;
    logic               scan_found, inta_first, inta_second, level_ok;

    function automatic logic [NUM_IRQ-1:0] lvl_mask(input logic [LVL_W-1:0] l);
        return NUM_IRQ'(1) << l;
    endfunction

    assign inta_first  = bus.inta_pulse && (state_reg == IDLE);
    assign inta_second = bus.inta_pulse && (state_reg == ACK1);
    assign grant_level = LVL_W'(onehot_index(32'(bus.grant)));
    assign eligible    = bus.special_mask_mode ? ~bus.imr : '1;

    // Level codes past NUM_IRQ-1 only exist when NUM_IRQ is not a power of two.
    if ((1 << LVL_W) == NUM_IRQ) begin : g_pow2
        assign level_ok = 1'b1;
    end else begin : g_npow2
        assign level_ok = (bus.ocw2_level <= TOP_LVL);
    end

    isr_prio_scan #(
        .NUM_IRQ (NUM_IRQ),
        .LVL_W   (LVL_W)
    ) u_scan (
        .req         (in_service_reg & eligible),
        .lowest_prio (lowest_prio_reg),
        .found       (scan_found),
        .level       (scan_level)
    );

    // AEOI is evaluated first so a same-cycle OCW2 overrides last_serviced and rotation.
    always_comb begin
        clr_mask           = '0;
        set_mask           = '0;
        last_serviced_next = last_serviced_reg;
        lowest_prio_next   = lowest_prio_reg;
`ifdef ISR_ROTATION_EN
        auto_rotate_next   = auto_rotate_reg;
`endif
        if (inta_second && bus.aeoi_mode && !spurious_reg) begin
            clr_mask           = clr_mask | lvl_mask(ack_level_reg);
            last_serviced_next = lvl_mask(ack_level_reg);
`ifdef ISR_ROTATION_EN
            if (auto_rotate_reg) lowest_prio_next = ack_level_reg;
`endif
        end
        if (inta_first) set_mask = bus.grant;
        if (bus.ocw2_valid) begin
            case (bus.ocw2_cmd)
                OCW2_NS_EOI, OCW2_ROT_NS: begin
                    if (scan_found) begin
                        clr_mask           = clr_mask | lvl_mask(scan_level);
                        last_serviced_next = lvl_mask(scan_level);
`ifdef ISR_ROTATION_EN
                        if (bus.ocw2_cmd == OCW2_ROT_NS) lowest_prio_next = scan_level;
`endif
                    end
                end
                OCW2_SP_EOI, OCW2_ROT_SP: begin
                    if (level_ok) begin
                        clr_mask           = clr_mask | lvl_mask(bus.ocw2_level);
                        last_serviced_next = lvl_mask(bus.ocw2_level);
`ifdef ISR_ROTATION_EN
                        if (bus.ocw2_cmd == OCW2_ROT_SP) lowest_prio_next = bus.ocw2_level;
`endif
                    end
                end
                OCW2_SET_PRIO: begin
`ifdef ISR_ROTATION_EN
                    if (level_ok) lowest_prio_next = bus.ocw2_level;
`endif
                end
                OCW2_ROT_AEOI_SET: begin
`ifdef ISR_ROTATION_EN
                    auto_rotate_next = 1'b1;
`endif
                end
                OCW2_ROT_AEOI_CLR: begin
`ifdef ISR_ROTATION_EN
                    auto_rotate_next = 1'b0;
`endif
                end
                OCW2_NOP: ;
                default: ;
            endcase
        end
        in_service_next = (in_service_reg & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= IDLE;
            in_service_reg    <= '0;
            last_serviced_reg <= '0;
            lowest_prio_reg   <= TOP_LVL;
            ack_level_reg     <= TOP_LVL;
            ack_busy_reg      <= 1'b0;
            spurious_reg      <= 1'b0;
`ifdef ISR_ROTATION_EN
            auto_rotate_reg   <= 1'b0;
`endif
        end else begin
            in_service_reg    <= in_service_next;
            last_serviced_reg <= last_serviced_next;
            lowest_prio_reg   <= lowest_prio_next;
`ifdef ISR_ROTATION_EN
            auto_rotate_reg   <= auto_rotate_next;
`endif
            case (state_reg)
                IDLE: begin
                    if (bus.inta_pulse) begin
                        state_reg    <= ACK1;
                        ack_busy_reg <= 1'b1;
                        if (bus.grant != '0) begin
                            ack_level_reg <= grant_level;
                            spurious_reg  <= 1'b0;
                        end else begin
                            ack_level_reg <= TOP_LVL;
                            spurious_reg  <= 1'b1;
                        end
                    end
                end
                ACK1: begin
                    if (bus.inta_pulse) begin
                        state_reg    <= IDLE;
                        ack_busy_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.in_service    = in_service_reg;
    assign bus.last_serviced = last_serviced_reg;
    assign bus.ack_level     = ack_level_reg;
    assign bus.ack_busy      = ack_busy_reg;
    assign bus.spurious      = spurious_reg;
    assign bus.lowest_prio   = lowest_prio_reg;

endmodule

// File: tb/tb_isr_ctrl.sv
// Bench for isr_ctrl: directed vector table, rotation sequences and randomized
// traffic against a level-based reference model.
module tb_isr_ctrl;

`ifdef ISR_ROTATION_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    isr_ctrl_if #(.NUM_IRQ(8)) bus ();

    isr_ctrl #(.NUM_IRQ(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int    checks   = 0;
    int    failures = 0;
    string tag      = "init";

    // Reference model state, kept as per-level bits and integer levels.
    bit m_isr [8];
    int m_last;
    int m_prio;
    int m_ackl;
    bit m_auto;
    bit m_busy;
    bit m_spur;

    function automatic logic [7:0] mask_of(input int l);
        logic [7:0] v;
        v = '0;
        if (l >= 0) v[l] = 1'b1;
        return v;
    endfunction

    function automatic logic [7:0] model_isr();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_isr[i];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s/%s actual=%0h required=%0h", tag, name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_isr[i] = 1'b0;
        m_last = -1; m_prio = 7; m_ackl = 7;
        m_auto = 0;  m_busy = 0; m_spur = 0;
    endtask

    task automatic model_step(input bit rst, input bit aeoi, input bit smm, input logic [7:0] imr,
                              input logic [7:0] grant, input bit inta, input bit ov,
                              input logic [2:0] cmd, input logic [2:0] lvl);
        bit n_isr [8];
        int n_last, n_prio, n_ackl, hi;
        bit n_auto, n_busy, n_spur, r, sl, e;
        if (rst) begin
            model_reset();
            return;
        end
        // Highest-priority eligible level: walk upward from the level after lowest_prio.
        hi = -1;
        for (int k = 1; k <= 8; k++) begin
            int l;
            l = (m_prio + k) % 8;
            if (hi < 0 && m_isr[l] && !(smm && imr[l])) hi = l;
        end
        n_isr = m_isr; n_last = m_last; n_prio = m_prio; n_ackl = m_ackl;
        n_auto = m_auto; n_busy = m_busy; n_spur = m_spur;
        if (inta) begin
            if (m_busy) begin
                n_busy = 0;
                if (aeoi && !m_spur) begin
                    n_isr[m_ackl] = 0;
                    n_last = m_ackl;
                    if (ROT && m_auto) n_prio = m_ackl;
                end
            end else begin
                n_busy = 1;
                if (grant == 8'h00) begin
                    n_ackl = 7; n_spur = 1;
                end else begin
                    n_spur = 0;
                    for (int k = 7; k >= 0; k--) if (grant[k]) n_ackl = k;
                end
            end
        end
        if (ov) begin
            r = cmd[2]; sl = cmd[1]; e = cmd[0];
            if (e && !sl && hi >= 0) begin
                n_isr[hi] = 0; n_last = hi;
                if (r && ROT) n_prio = hi;
            end
            if (e && sl) begin
                n_isr[lvl] = 0; n_last = int'(lvl);
                if (r && ROT) n_prio = int'(lvl);
            end
            if (!e && sl && r && ROT) n_prio = int'(lvl);
            if (!e && !sl && ROT) n_auto = r;
        end
        if (inta && !m_busy)
            for (int k = 0; k < 8; k++) if (grant[k]) n_isr[k] = 1;
        m_isr = n_isr; m_last = n_last; m_prio = n_prio; m_ackl = n_ackl;
        m_auto = n_auto; m_busy = n_busy; m_spur = n_spur;
    endtask

    task automatic compare_model();
        check("m_isr",  32'(bus.in_service),    32'(model_isr()));
        check("m_last", 32'(bus.last_serviced), 32'(mask_of(m_last)));
        check("m_ackl", 32'(bus.ack_level),     32'(m_ackl));
        check("m_busy", 32'(bus.ack_busy),      32'(m_busy));
        check("m_spur", 32'(bus.spurious),      32'(m_spur));
        check("m_prio", 32'(bus.lowest_prio),   32'(m_prio));
    endtask

    task automatic cycle(input bit rst, input bit aeoi, input bit smm, input logic [7:0] imr,
                         input logic [7:0] grant, input bit inta, input bit ov,
                         input logic [2:0] cmd, input logic [2:0] lvl);
        reset = rst;
        bus.aeoi_mode = aeoi; bus.special_mask_mode = smm; bus.imr = imr;
        bus.grant = grant; bus.inta_pulse = inta; bus.ocw2_valid = ov;
        bus.ocw2_cmd = cmd; bus.ocw2_level = lvl;
        @(posedge clk);
        model_step(rst, aeoi, smm, imr, grant, inta, ov, cmd, lvl);
        #1;
        compare_model();
    endtask

    task automatic inta_pair(input bit aeoi, input logic [7:0] grant);
        cycle(0, aeoi, 0, 8'h00, grant, 1, 0, 3'b000, 3'd0);
        cycle(0, aeoi, 0, 8'h00, grant, 1, 0, 3'b000, 3'd0);
    endtask

    task automatic ocw2(input logic [2:0] cmd, input logic [2:0] lvl);
        cycle(0, 0, 0, 8'h00, 8'h00, 0, 1, cmd, lvl);
    endtask

    typedef struct {
        bit         aeoi, smm;
        logic [7:0] imr, grant;
        bit         inta, ov;
        logic [2:0] cmd, lvl;
        logic [7:0] e_isr, e_last;
        bit         e_busy;
        logic [2:0] e_ackl;
        bit         e_spur;
    } vec_t;

    vec_t tbl [20];

    initial begin
        reset = 1'b1;
        bus.aeoi_mode = 0; bus.special_mask_mode = 0; bus.imr = '0; bus.grant = '0;
        bus.inta_pulse = 0; bus.ocw2_valid = 0; bus.ocw2_cmd = '0; bus.ocw2_level = '0;
        model_reset();

        tbl[0]  = '{0,0,8'h00,8'h08,1,0,3'b000,3'd0, 8'h08,8'h00,1,3'd3,0};
        tbl[1]  = '{0,0,8'h00,8'h08,1,0,3'b000,3'd0, 8'h08,8'h00,0,3'd3,0};
        tbl[2]  = '{0,0,8'h00,8'h02,1,0,3'b000,3'd0, 8'h0A,8'h00,1,3'd1,0};
        tbl[3]  = '{0,0,8'h00,8'h02,1,0,3'b000,3'd0, 8'h0A,8'h00,0,3'd1,0};
        tbl[4]  = '{0,0,8'h00,8'h00,0,1,3'b001,3'd0, 8'h08,8'h02,0,3'd1,0};
        tbl[5]  = '{0,0,8'h00,8'h02,1,0,3'b000,3'd0, 8'h0A,8'h02,1,3'd1,0};
        tbl[6]  = '{0,0,8'h00,8'h02,1,0,3'b000,3'd0, 8'h0A,8'h02,0,3'd1,0};
        tbl[7]  = '{0,1,8'h02,8'h00,0,1,3'b001,3'd0, 8'h02,8'h08,0,3'd1,0};
        tbl[8]  = '{0,0,8'h00,8'h00,0,1,3'b011,3'd1, 8'h00,8'h02,0,3'd1,0};
        tbl[9]  = '{0,0,8'h00,8'h00,0,1,3'b011,3'd6, 8'h00,8'h40,0,3'd1,0};
        tbl[10] = '{0,0,8'h00,8'h00,1,0,3'b000,3'd0, 8'h00,8'h40,1,3'd7,1};
        tbl[11] = '{1,0,8'h00,8'h00,1,0,3'b000,3'd0, 8'h00,8'h40,0,3'd7,1};
        tbl[12] = '{0,0,8'h00,8'h20,1,0,3'b000,3'd0, 8'h20,8'h40,1,3'd5,0};
        tbl[13] = '{0,0,8'h00,8'h20,1,0,3'b000,3'd0, 8'h20,8'h40,0,3'd5,0};
        tbl[14] = '{1,0,8'h00,8'h04,1,1,3'b011,3'd2, 8'h24,8'h04,1,3'd2,0};
        tbl[15] = '{1,0,8'h00,8'h00,1,1,3'b011,3'd5, 8'h00,8'h20,0,3'd2,0};
        tbl[16] = '{1,0,8'h00,8'h01,1,0,3'b000,3'd0, 8'h01,8'h20,1,3'd0,0};
        tbl[17] = '{1,0,8'h00,8'h01,1,0,3'b000,3'd0, 8'h00,8'h01,0,3'd0,0};
        tbl[18] = '{1,0,8'h00,8'h00,0,1,3'b010,3'd3, 8'h00,8'h01,0,3'd0,0};
        tbl[19] = '{1,0,8'h00,8'h00,0,1,3'b001,3'd0, 8'h00,8'h01,0,3'd0,0};

        tag = "reset";
        cycle(1, 0, 0, 8'h00, 8'h00, 0, 0, 3'b000, 3'd0);
        cycle(1, 0, 0, 8'h00, 8'h00, 0, 0, 3'b000, 3'd0);
        check("isr",  32'(bus.in_service),    32'h00);
        check("last", 32'(bus.last_serviced), 32'h00);
        check("ackl", 32'(bus.ack_level),     32'd7);
        check("busy", 32'(bus.ack_busy),      32'd0);
        check("spur", 32'(bus.spurious),      32'd0);
        check("prio", 32'(bus.lowest_prio),   32'd7);
        $display("reset: isr=%02h prio=%0d", bus.in_service, bus.lowest_prio);

        for (int i = 0; i < 20; i++) begin
            tag = $sformatf("vec%0d", i);
            cycle(0, tbl[i].aeoi, tbl[i].smm, tbl[i].imr, tbl[i].grant, tbl[i].inta,
                  tbl[i].ov, tbl[i].cmd, tbl[i].lvl);
            check("isr",  32'(bus.in_service),    32'(tbl[i].e_isr));
            check("last", 32'(bus.last_serviced), 32'(tbl[i].e_last));
            check("busy", 32'(bus.ack_busy),      32'(tbl[i].e_busy));
            check("ackl", 32'(bus.ack_level),     32'(tbl[i].e_ackl));
            check("spur", 32'(bus.spurious),      32'(tbl[i].e_spur));
            check("prio", 32'(bus.lowest_prio),   32'd7);
            $display("vec%0d: inta=%0b ocw2=%0b cmd=%03b lvl=%0d -> isr=%02h last=%02h busy=%0b ackl=%0d spur=%0b",
                     i, tbl[i].inta, tbl[i].ov, tbl[i].cmd, tbl[i].lvl, bus.in_service,
                     bus.last_serviced, bus.ack_busy, bus.ack_level, bus.spurious);
        end

        // AEOI with auto-rotation
        tag = "rotA";
        cycle(1, 0, 0, 8'h00, 8'h00, 0, 0, 3'b000, 3'd0);
        cycle(0, 1, 0, 8'h00, 8'h00, 0, 1, 3'b100, 3'd0);
        cycle(0, 1, 0, 8'h00, 8'h10, 1, 0, 3'b000, 3'd0);
        check("isr1", 32'(bus.in_service), 32'h10);
        cycle(0, 1, 0, 8'h00, 8'h10, 1, 0, 3'b000, 3'd0);
        check("isr2", 32'(bus.in_service),    32'h00);
        check("last", 32'(bus.last_serviced), 32'h10);
        check("prio", 32'(bus.lowest_prio),   ROT ? 32'd4 : 32'd7);
        $display("rotA: isr=%02h last=%02h prio=%0d", bus.in_service, bus.last_serviced, bus.lowest_prio);

        // Rotate on specific EOI
        tag = "rotB";
        ocw2(3'b000, 3'd0);
        inta_pair(0, 8'h20);
        ocw2(3'b111, 3'd5);
        check("isr",  32'(bus.in_service),    32'h00);
        check("last", 32'(bus.last_serviced), 32'h20);
        check("prio", 32'(bus.lowest_prio),   ROT ? 32'd5 : 32'd7);
        $display("rotB: isr=%02h prio=%0d", bus.in_service, bus.lowest_prio);

        // Rotating non-specific EOI picks by rotated priority, then set-priority
        tag = "rotC";
        inta_pair(0, 8'h02);
        inta_pair(0, 8'h80);
        ocw2(3'b101, 3'd0);
        check("isr",  32'(bus.in_service),    ROT ? 32'h02 : 32'h80);
        check("last", 32'(bus.last_serviced), ROT ? 32'h80 : 32'h02);
        check("prio", 32'(bus.lowest_prio),   32'd7);
        ocw2(3'b110, 3'd2);
        check("prio2", 32'(bus.lowest_prio),  ROT ? 32'd2 : 32'd7);
        ocw2(3'b001, 3'd0);
        check("isr2",  32'(bus.in_service),    32'h00);
        check("last2", 32'(bus.last_serviced), ROT ? 32'h02 : 32'h80);
        $display("rotC: isr=%02h last=%02h prio=%0d", bus.in_service, bus.last_serviced, bus.lowest_prio);

        // Reset while waiting for the second INTA with every level in service
        tag = "rstD";
        cycle(1, 0, 0, 8'h00, 8'h00, 0, 0, 3'b000, 3'd0);
        for (int i = 0; i < 7; i++) inta_pair(0, mask_of(i));
        cycle(0, 0, 0, 8'h00, 8'h80, 1, 0, 3'b000, 3'd0);
        check("isr_ff", 32'(bus.in_service), 32'hFF);
        check("busy1",  32'(bus.ack_busy),   32'd1);
        cycle(1, 0, 0, 8'h00, 8'h00, 0, 0, 3'b000, 3'd0);
        check("isr",  32'(bus.in_service),  32'h00);
        check("busy", 32'(bus.ack_busy),    32'd0);
        check("prio", 32'(bus.lowest_prio), 32'd7);
        check("ackl", 32'(bus.ack_level),   32'd7);
        $display("rstD: isr=%02h busy=%0b prio=%0d", bus.in_service, bus.ack_busy, bus.lowest_prio);

        tag = "rand";
        for (int n = 0; n < 1500; n++) begin
            bit         rst, aeoi, smm, inta, ov;
            logic [7:0] imr, grant;
            logic [2:0] cmd, lvl;
            rst   = ($urandom_range(0, 99) == 0);
            aeoi  = ($urandom_range(0, 2) == 0);
            smm   = $urandom_range(0, 1) == 1;
            imr   = 8'($urandom);
            grant = ($urandom_range(0, 5) == 0) ? 8'h00 : mask_of($urandom_range(0, 7));
            inta  = ($urandom_range(0, 2) == 0);
            ov    = ($urandom_range(0, 3) == 0);
            cmd   = 3'($urandom);
            lvl   = 3'($urandom);
            cycle(rst, aeoi, smm, imr, grant, inta, ov, cmd, lvl);
            if (inta || ov || rst)
                $display("rand%0d: rst=%0b inta=%0b g=%02h ocw2=%0b cmd=%03b lvl=%0d -> isr=%02h last=%02h prio=%0d",
                         n, rst, inta, grant, ov, cmd, lvl, bus.in_service,
                         bus.last_serviced, bus.lowest_prio);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/isr_ctrl.md
Name: isr_ctrl

Overview:
- Parametrised, clocked in-service register controller for the interrupt controller. Generalised from 8 to NUM_IRQ levels.
- Owns the two-pulse INTA acknowledge sequence, AEOI, and OCW2 EOI commands: non-specific, specific and rotating.
- Also owns the special-mask interaction and a rotating priority pointer.
- Sits between the priority resolver, which supplies the one-hot grant, and control logic, which supplies INTA strobes and OCW2 commands. Feeds ISR state and the priority base back to the resolver.

Parameters:
- NUM_IRQ, 8, number of interrupt levels (2..32).
- LVL_W, $clog2(NUM_IRQ), width of a level index.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- aeoi_mode  in  1  1 = automatic EOI (ICW4), 0 = normal EOI.
- special_mask_mode  in  1  special mask mode enabled (OCW3).
- imr  in  NUM_IRQ  interrupt mask register.
- grant  in  NUM_IRQ  one-hot highest-priority pending request from resolver; all-zero = none.
- inta_pulse  in  1  one-cycle strobe per INTA edge from control logic.
- ocw2_valid  in  1  one-cycle strobe, OCW2 written.
- ocw2_cmd  in  3  OCW2 D7..D5 (R, SL, EOI).
- ocw2_level  in  LVL_W  OCW2 L2..L0.
- in_service  out  NUM_IRQ  ISR bits.
- last_serviced  out  NUM_IRQ  one-hot of most recently cleared level.
- ack_level  out  LVL_W  level acknowledged in current sequence (vector low bits).
- ack_busy  out  1  high between first and second INTA.
- spurious  out  1  first INTA arrived with grant == 0.
- lowest_prio  out  LVL_W  level currently holding lowest priority.

Behaviour:
- Reset values: in_service=0, last_serviced=0, ack_level=NUM_IRQ-1, ack_busy=0, spurious=0, lowest_prio=NUM_IRQ-1, auto_rotate flag=0, state IDLE.
- All outputs are registered. Effects become visible the cycle after the strobe.
- INTA FSM:
  - IDLE, inta_pulse, grant!=0: in_service |= grant; ack_level = index(grant); spurious=0; go ACK1.
  - IDLE, inta_pulse, grant==0: ack_level=NUM_IRQ-1; spurious=1; no ISR change; go ACK1.
  - ACK1, inta_pulse: go IDLE.
    - If aeoi_mode and !spurious: clear bit ack_level and set last_serviced to it.
    - If auto_rotate is also set: lowest_prio=ack_level.
  - ACK1 waits indefinitely for the second pulse. No timeout.
- Priority order: highest = (lowest_prio+1) mod NUM_IRQ, then ascending with wrap.
- OCW2 commands, acted on when ocw2_valid:
  - 001 non-specific EOI: clear the highest-priority set ISR bit. With special_mask_mode, ISR bits whose imr bit is 1 are skipped. If no eligible bit is set, nothing happens.
  - 011 specific EOI: clear bit ocw2_level.
  - 101 rotate on non-specific EOI: as 001, then lowest_prio = cleared level. No rotation if nothing was cleared.
  - 111 rotate on specific EOI: as 011, then lowest_prio=ocw2_level.
  - 110 set priority: lowest_prio=ocw2_level. ISR unchanged.
  - 100 and 000: set and clear the auto_rotate flag respectively.
  - 010: no operation.
  - Every clear sets last_serviced to the one-hot of the cleared level. Otherwise last_serviced holds.
- Simultaneous events in one cycle:
  - An EOI clear and an INTA set are both applied; set wins on the same bit.
  - A second-INTA AEOI clear and an EOI clear on different bits both apply. last_serviced reports the EOI-cleared level.
  - A rotation from OCW2 has priority over an AEOI rotation.
- Specific EOI on a bit that is already clear has no ISR effect, but still updates last_serviced and any rotation.
- Reset mid-sequence returns to the reset state in one cycle.

Optional Feature:
- ISR_ROTATION_EN defined: rotation commands (101, 111, 110, 100/000) and AEOI auto-rotation behave as above.
- ISR_ROTATION_EN undefined:
  - lowest_prio is fixed at NUM_IRQ-1, so level 0 is highest.
  - 101 behaves as 001, and 111 behaves as 011.
  - 110, 100 and 000 are no-ops, and the auto_rotate flag does not exist.

Decomposition:
- Package isr_pkg holds:
  - OCW2 command localparams: OCW2_NS_EOI, OCW2_SP_EOI, OCW2_ROT_NS, OCW2_ROT_SP, OCW2_SET_PRIO, OCW2_ROT_AEOI_SET, OCW2_ROT_AEOI_CLR, OCW2_NOP.
  - The FSM state encoding (IDLE, ACK1).
- One sub-module, isr_prio_scan: combinational rotating find-first over (in_service & eligible mask) from lowest_prio+1. Outputs found flag and level.

Test Plan:
- AEOI off, grant=8'h08, two inta_pulse → in_service=8'h08 after pulse 1, ack_busy=1, ack_level=3; after pulse 2 ISR still 8'h08, ack_busy=0.
- ISR=8'h0A, lowest_prio=7, OCW2 001 → ISR=8'h08, last_serviced=8'h02. Repeat with special_mask_mode=1, imr=8'h02 → ISR=8'h02.
- AEOI on, rotation enabled, OCW2 100, then INTA pair with grant=8'h10 → ISR 8'h10 then 8'h00, lowest_prio=4, last_serviced=8'h10.
- OCW2 111 level 5 with ISR=8'h20 → ISR=0, lowest_prio=5. The same command with ISR_ROTATION_EN undefined → lowest_prio stays 7.
- First INTA with grant=0 → spurious=1, ack_level=7, ISR unchanged. AEOI second pulse clears nothing.
- reset asserted while in ACK1 with ISR=8'hFF → next cycle ISR=0, ack_busy=0, lowest_prio=7.
